// File: rtl/amo_bus_master_if.sv
// Bus side of the atomic-capable bus master.
// The master drives the request (strobe, write enable, address, address tag,
// write data, byte selects). The slave returns ack/err, read data and a
// one-bit data tag that reports reservation success on an SC write.
interface amo_bus_master_if;
   logic        stb_o;
   logic        we_o;
   logic [31:0] addr_o;
   logic [2:0]  addr_tag_o;
   logic [31:0] data_o;
   logic [3:0]  sel_o;
   logic        ack_i;
   logic        err_i;
   logic [31:0] data_i;
   logic        data_tag_i;

   modport master (
      output stb_o, we_o, addr_o, addr_tag_o, data_o, sel_o,
      input  ack_i, err_i, data_i, data_tag_i
   );

   modport slave (
      input  stb_o, we_o, addr_o, addr_tag_o, data_o, sel_o,
      output ack_i, err_i, data_i, data_tag_i
   );
endinterface

// File: rtl/amo_bus_master.sv
// Bus master that executes one core memory operation at a time: plain
// load/store, LR/SC, and read-modify-write AMOs as a locked read followed by
// an unlocking write.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i             core request, taken only when idle
//   op_i              operation code (0..12 legal)
//   addr_i, wdata_i   core address and write data
//   be_i              byte enables for LOAD/STORE
//   busy_o            operation in flight
//   done_o, fault_o   one-cycle completion pulse and its fault flag
//   rdata_o           result, valid while done_o=1
//   bus               master side of amo_bus_master_if
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req_i
// READ  | read strobe out, waiting for ack/err/timeout
// CALC  | one cycle to compute the AMO result from the old value
// WRITE | write strobe out, waiting for ack/err/timeout
// DONE  | done_o pulse with result/fault, back to IDLE
module amo_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic [3:0]       op_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      wdata_i,
   input  logic [3:0]       be_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             fault_o,
   output logic [31:0]      rdata_o,
   amo_bus_master_if.master bus
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LR    = 4'd2;
   localparam logic [3:0] OP_SC    = 4'd3;
   localparam logic [3:0] OP_SWAP  = 4'd4;
   localparam logic [3:0] OP_ADD   = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_AND   = 4'd7;
   localparam logic [3:0] OP_OR    = 4'd8;
   localparam logic [3:0] OP_MIN   = 4'd9;
   localparam logic [3:0] OP_MAX   = 4'd10;
   localparam logic [3:0] OP_MINU  = 4'd11;
   localparam logic [3:0] OP_MAXU  = 4'd12;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    op_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;      // read data; for AMOs this is the old value
   logic          fault_q;
   logic [CW-1:0] tmo_q;        // down-counter, expiry at zero
   logic [31:0]   addr_q;
   logic [2:0]    tag_q;
   logic [31:0]   data_q;
   logic [3:0]    sel_q;

   logic          op_atomic, reject, in_bus, bus_err, bus_ack;
   logic [2:0]    tag_i;
   logic [31:0]   new_val;

   assign op_atomic = (op_i >= OP_LR);
   assign reject    = (op_i > OP_MAXU) || (op_atomic && (addr_i[1:0] != 2'b00));
   assign tag_i     = (op_i == OP_LR) ? 3'b011 :
                      (op_i == OP_SC) ? 3'b010 :
                      (op_i >= OP_SWAP) ? 3'b101 : 3'b000;

   // Timeout counts as an error; err also wins over a simultaneous ack.
   assign in_bus  = (state_q == S_READ) || (state_q == S_WRITE);
   assign bus_err = in_bus && (bus.err_i || (!bus.ack_i && (tmo_q == '0)));
   assign bus_ack = in_bus && bus.ack_i && !bus.err_i;

   always_comb begin
      new_val = wdata_q;
      case (op_q)
         OP_ADD:  new_val = rdata_q + wdata_q;
         OP_XOR:  new_val = rdata_q ^ wdata_q;
         OP_AND:  new_val = rdata_q & wdata_q;
         OP_OR:   new_val = rdata_q | wdata_q;
         OP_MIN:  new_val = ($signed(rdata_q) < $signed(wdata_q)) ? rdata_q : wdata_q;
         OP_MAX:  new_val = ($signed(rdata_q) > $signed(wdata_q)) ? rdata_q : wdata_q;
         OP_MINU: new_val = (rdata_q < wdata_q) ? rdata_q : wdata_q;
         OP_MAXU: new_val = (rdata_q > wdata_q) ? rdata_q : wdata_q;
         default: new_val = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (reject)
                  state_d = S_DONE;
               else if ((op_i == OP_STORE) || (op_i == OP_SC))
                  state_d = S_WRITE;
               else
                  state_d = S_READ;
            end
         end
         S_READ: begin
            if (bus_err)
               state_d = S_DONE;
            else if (bus_ack)
               state_d = (op_q >= OP_SWAP) ? S_CALC : S_DONE;
         end
         S_CALC:  state_d = S_WRITE;
         S_WRITE: if (bus_err || bus_ack) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         tmo_q   <= '0;
         addr_q  <= '0;
         tag_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  op_q    <= op_i;
                  wdata_q <= wdata_i;
                  addr_q  <= addr_i;
                  data_q  <= wdata_i;
                  sel_q   <= op_atomic ? 4'hF : be_i;
                  tag_q   <= tag_i;
                  rdata_q <= '0;
                  fault_q <= reject;
                  tmo_q   <= TMO_LOAD;
               end
            end
            S_READ, S_WRITE: begin
               if (bus_err)
                  fault_q <= 1'b1;
               else if (bus_ack) begin
                  if (state_q == S_READ)
                     rdata_q <= bus.data_i;
                  else if (op_q == OP_SC)
                     rdata_q <= bus.data_tag_i ? 32'd0 : 32'd1;
               end
               if (tmo_q != '0)
                  tmo_q <= tmo_q - CW'(1);
            end
            S_CALC: begin
               data_q <= new_val;
               tag_q  <= 3'b100;   // AMO write releases the lock
               tmo_q  <= TMO_LOAD;
            end
            default: ;
         endcase
      end
   end

   assign bus.stb_o      = in_bus;
   assign bus.we_o       = (state_q == S_WRITE);
   assign bus.addr_o     = addr_q;
   assign bus.addr_tag_o = tag_q;
   assign bus.data_o     = data_q;
   assign bus.sel_o      = sel_q;

   assign busy_o  = (state_q == S_READ) || (state_q == S_CALC) || (state_q == S_WRITE);
   assign done_o  = (state_q == S_DONE);
   assign fault_o = done_o && fault_q;
   assign rdata_o = rdata_q;

endmodule

// File: tb/tb_amo_bus_master.sv
// Self-checking bench for amo_bus_master. The bench plays the bus slave
// backed by a word memory and an LR reservation, and predicts every bus
// request and core result from the operation semantics.
module tb_amo_bus_master;
   localparam int TMO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic [3:0]  op_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic        busy_o;
   logic        done_o;
   logic        fault_o;
   logic [31:0] rdata_o;

   amo_bus_master_if bus();

   amo_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .op_i    (op_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .be_i    (be_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .fault_o (fault_o),
      .rdata_o (rdata_o),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [logic [31:0]];
   bit          resv_v = 1'b0;
   logic [31:0] resv_a = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic mem_rd(input logic [31:0] a, output logic [31:0] v);
      logic [31:0] key;
      key = a & ~32'h3;
      if (!mem.exists(key)) mem[key] = $urandom;
      v = mem[key];
   endtask

   function automatic logic [31:0] amo_new(input logic [3:0] op, input logic [31:0] old,
                                           input logic [31:0] w);
      int so, sw;
      so = old;
      sw = w;
      case (op)
         4'd5:    return old + w;
         4'd6:    return old ^ w;
         4'd7:    return old & w;
         4'd8:    return old | w;
         4'd9:    return (so < sw) ? old : w;
         4'd10:   return (so > sw) ? old : w;
         4'd11:   return (old < w) ? old : w;
         4'd12:   return (old > w) ? old : w;
         default: return w;
      endcase
   endfunction

   // Serves one strobe. mode 0..2: ack after that many waiting cycles;
   // 3: err (with a random ack alongside); 4: silent until the timeout.
   // Entered and left at a negedge; on return the DUT has left the state.
   task automatic bus_phase(input string nm, input bit exp_we, input logic [31:0] exp_addr,
                            input logic [2:0] exp_tag, input logic [3:0] exp_sel,
                            input bit chk_data, input logic [31:0] exp_data, input int mode,
                            input logic [31:0] rsp_data, input bit rsp_tag, output bit ok);
      bit fin;
      ok = 1'b0;
      for (int c = 0; c < TMO; c++) begin
         chk({nm, ".stb"}, bus.stb_o, 1);
         chk({nm, ".we"}, bus.we_o, exp_we);
         chk({nm, ".addr"}, bus.addr_o, exp_addr);
         chk({nm, ".tag"}, bus.addr_tag_o, exp_tag);
         chk({nm, ".sel"}, bus.sel_o, exp_sel);
         chk({nm, ".busy"}, busy_o, 1);
         if (chk_data) chk({nm, ".data"}, bus.data_o, exp_data);
         fin = (mode < 3 && c == mode) || (mode == 3 && c == 0) || (mode == 4 && c == TMO - 1);
         req_i = fin ? 1'b0 : 1'($urandom % 2);
         bus.data_i = $urandom;
         bus.data_tag_i = 1'($urandom % 2);
         if (mode < 3 && c == mode) begin
            bus.ack_i = 1'b1;
            bus.data_i = rsp_data;
            bus.data_tag_i = rsp_tag;
         end
         if (mode == 3 && c == 0) begin
            bus.err_i = 1'b1;
            bus.ack_i = 1'($urandom % 2);
         end
         @(negedge clk_i);
         bus.ack_i = 1'b0;
         bus.err_i = 1'b0;
         if (fin) begin
            ok = (mode < 3);
            break;
         end
      end
   endtask

   task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int rmode, input int wmode);
      bit reject, is_amo, has_read, has_write, ok, exp_fault, valid;
      logic [31:0] old, nv, exp_rd, cur;
      logic [2:0] rtag, wtag;
      logic [3:0] sel;
      reject    = (op > 12) || (op >= 2 && addr[1:0] != 2'b00);
      is_amo    = (op >= 4 && op <= 12);
      has_read  = (op == 0 || op == 2 || is_amo);
      has_write = (op == 1 || op == 3 || is_amo);
      sel  = (op >= 2) ? 4'hF : be;
      rtag = (op == 0) ? 3'b000 : (op == 2) ? 3'b011 : 3'b101;
      wtag = (op == 1) ? 3'b000 : (op == 3) ? 3'b010 : 3'b100;
      exp_fault = 1'b0;
      exp_rd = '0;
      old = '0;
      ok = 1'b1;

      req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata; be_i = be;
      @(negedge clk_i);
      req_i = 1'b0; op_i = 4'($urandom); addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom);

      if (reject) begin
         exp_fault = 1'b1;
      end else begin
         if (has_read) begin
            mem_rd(addr, old);
            bus_phase({nm, ".rd"}, 1'b0, addr, rtag, sel, 1'b0, '0, rmode, old, 1'b0, ok);
            if (!ok) exp_fault = 1'b1;
            else begin
               exp_rd = old;
               if (op == 2) begin resv_v = 1'b1; resv_a = addr; end
            end
         end
         if (ok && is_amo) begin
            chk({nm, ".calc_stb"}, bus.stb_o, 0);
            chk({nm, ".calc_busy"}, busy_o, 1);
            req_i = 1'($urandom % 2);
            @(negedge clk_i);
         end
         if (ok && has_write) begin
            nv = is_amo ? amo_new(op, old, wdata) : wdata;
            valid = (op == 3) && resv_v && (resv_a == addr);
            bus_phase({nm, ".wr"}, 1'b1, addr, wtag, sel, 1'b1, nv, wmode, $urandom, valid, ok);
            if (op == 3) resv_v = 1'b0;
            if (!ok) exp_fault = 1'b1;
            else begin
               if (op == 3) exp_rd = valid ? 32'd0 : 32'd1;
               if (op == 1) begin
                  mem_rd(addr, cur);
                  for (int b = 0; b < 4; b++)
                     if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                  mem[addr & ~32'h3] = cur;
               end
               if (is_amo || valid) mem[addr & ~32'h3] = nv;
            end
         end
      end

      req_i = 1'b0;
      chk({nm, ".done"}, done_o, 1);
      chk({nm, ".fault"}, fault_o, exp_fault);
      chk({nm, ".done_busy"}, busy_o, 0);
      chk({nm, ".done_stb"}, bus.stb_o, 0);
      if (!exp_fault) chk({nm, ".rdata"}, rdata_o, exp_rd);
      @(negedge clk_i);
      chk({nm, ".done_pulse"}, done_o, 0);
      chk({nm, ".idle_busy"}, busy_o, 0);
      chk({nm, ".idle_stb"}, bus.stb_o, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [3:0]  rop;
      logic [31:0] raddr;
      int pick;

      rst_i = 1'b1; req_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
      bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.data_i = '0; bus.data_tag_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst.stb", bus.stb_o, 0);
      chk("rst.we", bus.we_o, 0);
      chk("rst.busy", busy_o, 0);
      chk("rst.done", done_o, 0);
      chk("rst.fault", fault_o, 0);
      chk("rst.tag", bus.addr_tag_o, 0);
      chk("rst.rdata", rdata_o, 0);
      chk("rst.addr", bus.addr_o, 0);
      chk("rst.data", bus.data_o, 0);
      chk("rst.sel", bus.sel_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst.busy", busy_o, 0);

      mem[32'h1000] = 32'h7FFF_FFFF;
      do_op("amoadd", 4'd5, 32'h1000, 32'd1, 4'h0, 1, 0);
      mem[32'h1100] = 32'hFFFF_FFFF;
      do_op("amomin", 4'd9, 32'h1100, 32'd1, 4'h0, 0, 1);
      mem[32'h1100] = 32'hFFFF_FFFF;
      do_op("amominu", 4'd11, 32'h1100, 32'd1, 4'h0, 0, 0);
      do_op("lr", 4'd2, 32'h2000, 32'd0, 4'h0, 2, 0);
      do_op("sc_ok", 4'd3, 32'h2000, 32'hCAFE_F00D, 4'h0, 0, 2);
      do_op("sc_fail", 4'd3, 32'h2000, 32'h1234_5678, 4'h0, 0, 0);
      do_op("swap_mis", 4'd4, 32'h1002, 32'h5555_AAAA, 4'h0, 0, 0);
      do_op("illegal", 4'd14, 32'h3000, 32'h0, 4'hF, 0, 0);
      do_op("amo_rderr", 4'd6, 32'h1000, 32'hFFFF_0000, 4'h0, 3, 0);
      do_op("load_tmo", 4'd0, 32'h3000, 32'h0, 4'h3, 4, 0);
      do_op("amo_wrtmo", 4'd8, 32'h3004, 32'h0F0F_0F0F, 4'h0, 1, 4);
      do_op("store", 4'd1, 32'h3008, 32'h1122_3344, 4'b0101, 0, 1);
      do_op("load", 4'd0, 32'h3008, 32'h0, 4'b1111, 1, 0);

      // Reset while the AMO write strobe is out.
      mem[32'h1200] = 32'd5;
      req_i = 1'b1; op_i = 4'd5; addr_i = 32'h1200; wdata_i = 32'd3; be_i = 4'h0;
      @(negedge clk_i);
      req_i = 1'b0;
      bus_phase("rstmid.rd", 1'b0, 32'h1200, 3'b101, 4'hF, 1'b0, '0, 0, 32'd5, 1'b0, ok);
      @(negedge clk_i);
      chk("rstmid.wr_stb", bus.stb_o, 1);
      chk("rstmid.wr_data", bus.data_o, 32'd8);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rstmid.stb", bus.stb_o, 0);
      chk("rstmid.busy", busy_o, 0);
      chk("rstmid.done", done_o, 0);
      @(negedge clk_i);
      chk("rstmid.done2", done_o, 0);
      chk("rstmid.busy2", busy_o, 0);

      for (int n = 0; n < 60; n++) begin
         rop = (($urandom % 8) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
         case ($urandom % 4)
            0:       raddr = 32'h1000;
            1:       raddr = 32'h1004;
            2:       raddr = 32'h2000;
            default: raddr = 32'h3000;
         endcase
         if (($urandom % 6) == 0) raddr[1:0] = 2'($urandom_range(1, 3));
         pick = $urandom_range(0, 9);
         do_op("rand", rop, raddr, $urandom, 4'($urandom),
               (pick < 7) ? pick % 3 : (pick < 9 ? 3 : 4),
               ($urandom % 10 < 8) ? int'($urandom % 3) : int'($urandom_range(3, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
